// File: rtl/prog_chan_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : prog_chan_supervisor
// Brief    : Channel-FPGA configuration supervisor: resets and launches the
//            channel programmer, enforces a per-attempt timeout, retries a
//            bounded number of times and reports status and a failure mask.
//            Macro PROG_SUP_TIMER_EN enables the successful-attempt timer.
// Revision : 1.0
// ============================================================================
module prog_chan_supervisor #(
    parameter int TIMEOUT_CYCLES = 50000000,
    parameter int MAX_RETRIES    = 3,
    parameter int RESET_CYCLES   = 16,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_req,
    input  logic             abort_req,
    input  logic             prog_in_progress,
    input  logic [4:0]       prog_done,
    output logic             prog_start,
    output logic             prog_reset,
    output logic             busy,
    output logic             success,
    output logic             fail,
    output logic             aborted,
    output logic [3:0]       attempt,
    output logic [4:0]       fail_mask,
    output logic [CNT_W-1:0] prog_time
);

    localparam logic [2:0] c_IDLE        = 3'd0;
    localparam logic [2:0] c_RESET_PROG  = 3'd1;
    localparam logic [2:0] c_LAUNCH      = 3'd2;
    localparam logic [2:0] c_WAIT_ACTIVE = 3'd3;
    localparam logic [2:0] c_WAIT_DONE   = 3'd4;
    localparam logic [2:0] c_SUCCESS     = 3'd5;
    localparam logic [2:0] c_FAIL        = 3'd6;

    localparam int              c_RST_W        = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [c_RST_W-1:0] c_RST_LAST  = c_RST_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]   c_TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic               r_prog_start;
    logic               r_abort_pulse;
    logic [4:0]         r_sync1;
    logic [4:0]         r_done_s;
    logic [c_RST_W-1:0] r_rst_cnt;
    logic [CNT_W-1:0]   r_cnt;
    logic [3:0]         r_attempt;
    logic               r_aborted;
    logic [4:0]         r_fail_mask;

    logic w_busy_state;
    logic w_waiting;
    logic w_timeout;
    logic w_done_ok;
    logic w_can_retry;
    logic w_abort;
    logic w_retry;
    logic w_restart;

    // DONE pins come straight from the channel FPGAs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1  <= '0;
            r_done_s <= '0;
        end else begin
            r_sync1  <= prog_done;
            r_done_s <= r_sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_IDLE;
            r_prog_start  <= 1'b0;
            r_abort_pulse <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_prog_start  <= (w_next_state == c_WAIT_ACTIVE) || (w_next_state == c_WAIT_DONE);
            r_abort_pulse <= w_abort;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_abort      = 1'b0;
        w_retry      = 1'b0;
        w_restart    = 1'b0;
        w_busy_state = (r_state == c_RESET_PROG) || (r_state == c_LAUNCH) ||
                       (r_state == c_WAIT_ACTIVE) || (r_state == c_WAIT_DONE);
        w_waiting    = (r_state == c_WAIT_ACTIVE) || (r_state == c_WAIT_DONE);
        w_timeout    = w_waiting && (r_cnt >= c_TIMEOUT_LAST);
        w_done_ok    = !prog_in_progress && (r_done_s == 5'h1F);
        w_can_retry  = (int'(r_attempt) <= MAX_RETRIES);
        if (w_busy_state && abort_req) begin
            w_next_state = c_FAIL;
            w_abort      = 1'b1;
        end else begin
            case (r_state)
                c_IDLE, c_SUCCESS, c_FAIL: begin
                    if (start_req) begin
                        w_next_state = c_RESET_PROG;
                        w_restart    = 1'b1;
                    end
                end
                c_RESET_PROG: if (r_rst_cnt == c_RST_LAST) w_next_state = c_LAUNCH;
                c_LAUNCH:     w_next_state = c_WAIT_ACTIVE;
                c_WAIT_ACTIVE, c_WAIT_DONE: begin
                    // A completed attempt beats a timeout landing on the same cycle
                    if (r_state == c_WAIT_ACTIVE && prog_in_progress) begin
                        w_next_state = c_WAIT_DONE;
                    end else if (r_state == c_WAIT_DONE && w_done_ok) begin
                        w_next_state = c_SUCCESS;
                    end else if (w_timeout) begin
                        w_next_state = w_can_retry ? c_RESET_PROG : c_FAIL;
                        w_retry      = w_can_retry;
                    end
                end
                default: w_next_state = c_IDLE;
            endcase
        end
    end

    always_comb begin
        prog_start = r_prog_start;
        prog_reset = (r_state == c_RESET_PROG) || r_abort_pulse;
        busy       = w_busy_state;
        success    = (r_state == c_SUCCESS);
        fail       = (r_state == c_FAIL);
        aborted    = r_aborted;
        attempt    = r_attempt;
        fail_mask  = r_fail_mask;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rst_cnt   <= '0;
            r_cnt       <= '0;
            r_attempt   <= '0;
            r_aborted   <= 1'b0;
            r_fail_mask <= '0;
        end else begin
            if (r_state == c_RESET_PROG && w_next_state == c_RESET_PROG)
                r_rst_cnt <= r_rst_cnt + 1'b1;
            else
                r_rst_cnt <= '0;

            if (r_state == c_LAUNCH)
                r_cnt <= '0;
            else if (w_waiting)
                r_cnt <= r_cnt + 1'b1;

            if (w_restart) begin
                r_attempt   <= 4'd1;
                r_aborted   <= 1'b0;
                r_fail_mask <= '0;
            end else begin
                if (w_retry && r_attempt != 4'hF)
                    r_attempt <= r_attempt + 1'b1;
                if (w_abort)
                    r_aborted <= 1'b1;
                if (w_next_state == c_FAIL && r_state != c_FAIL)
                    r_fail_mask <= ~r_done_s;
            end
        end
    end

`ifdef PROG_SUP_TIMER_EN
    // The timeout counter already counts exactly the cycles since LAUNCH
    logic [CNT_W-1:0] r_prog_time;

    always_ff @(posedge clk) begin
        if (reset)
            r_prog_time <= '0;
        else if (w_restart)
            r_prog_time <= '0;
        else if (w_next_state == c_SUCCESS && r_state != c_SUCCESS)
            r_prog_time <= r_cnt;
    end

    assign prog_time = r_prog_time;
`else
    assign prog_time = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_prog_chan_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_chan_supervisor
// Brief    : Directed self-checking bench for prog_chan_supervisor.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_prog_chan_supervisor;

    localparam int TIMEOUT_CYCLES = 100;
    localparam int MAX_RETRIES    = 2;
    localparam int RESET_CYCLES   = 4;
    localparam int CNT_W          = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start_req = 1'b0;
    logic             abort_req = 1'b0;
    logic             prog_in_progress = 1'b0;
    logic [4:0]       prog_done = 5'h00;
    logic             prog_start;
    logic             prog_reset;
    logic             busy;
    logic             success;
    logic             fail;
    logic             aborted;
    logic [3:0]       attempt;
    logic [4:0]       fail_mask;
    logic [CNT_W-1:0] prog_time;

    int checks = 0;
    int passed = 0;

    prog_chan_supervisor #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .MAX_RETRIES    (MAX_RETRIES),
        .RESET_CYCLES   (RESET_CYCLES),
        .CNT_W          (CNT_W)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start_req        (start_req),
        .abort_req        (abort_req),
        .prog_in_progress (prog_in_progress),
        .prog_done        (prog_done),
        .prog_start       (prog_start),
        .prog_reset       (prog_reset),
        .busy             (busy),
        .success          (success),
        .fail             (fail),
        .aborted          (aborted),
        .attempt          (attempt),
        .fail_mask        (fail_mask),
        .prog_time        (prog_time)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start_req = 1'b1;
        tick();
        start_req = 1'b0;
    endtask

    // One programming attempt: observe the reset pulse, wait for launch,
    // then optionally play the programmer's busy/done handshake.
    task automatic attempt_cycle(input string tag, input logic [3:0] exp_att,
                                 input bit raise, input int hold, input logic [4:0] dval);
        int n;
        int w;
        n = 0;
        while (prog_reset !== 1'b1 && n < 400) begin tick(); n++; end
        prog_in_progress = 1'b0;
        checks++; if (prog_reset !== 1'b1) $display("FAIL %s_reset_seen got=%b exp=1", tag, prog_reset); else passed++;
        checks++; if (attempt !== exp_att) $display("FAIL %s_attempt got=%0d exp=%0d", tag, attempt, exp_att); else passed++;
        w = 0;
        while (prog_reset === 1'b1 && w < 50) begin tick(); w++; end
        checks++; if (w != RESET_CYCLES) $display("FAIL %s_reset_width got=%0d exp=%0d", tag, w, RESET_CYCLES); else passed++;
        n = 0;
        while (prog_start !== 1'b1 && n < 50) begin tick(); n++; end
        checks++; if (prog_start !== 1'b1) $display("FAIL %s_launch got=%b exp=1", tag, prog_start); else passed++;
        if (raise) begin
            tick(10);
            prog_in_progress = 1'b1;
            if (hold > 0) begin
                tick(hold);
                prog_in_progress = 1'b0;
                prog_done = dval;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        checks++; if ({prog_start, prog_reset, busy, success, fail, aborted} !== 6'b0)
            $display("FAIL reset_flags got=%b exp=000000", {prog_start, prog_reset, busy, success, fail, aborted}); else passed++;
        checks++; if (attempt !== 4'd0 || fail_mask !== 5'd0 || prog_time !== '0)
            $display("FAIL reset_values got=%0d/%h/%0d exp=0/00/0", attempt, fail_mask, prog_time); else passed++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_nominal();
        int n;
        prog_done = 5'h00;
        pulse_start();
        attempt_cycle("nominal", 4'd1, 1'b1, 50, 5'h1F);
        n = 0;
        while (success !== 1'b1 && n < 20) begin tick(); n++; end
        checks++; if (success !== 1'b1) $display("FAIL nominal_success got=%b exp=1", success); else passed++;
        checks++; if (attempt !== 4'd1 || fail !== 1'b0 || busy !== 1'b0 || prog_start !== 1'b0)
            $display("FAIL nominal_status got att=%0d fail=%b busy=%b start=%b exp 1/0/0/0", attempt, fail, busy, prog_start); else passed++;
`ifdef PROG_SUP_TIMER_EN
        checks++; if (prog_time < 59 || prog_time > 63) $display("FAIL nominal_prog_time got=%0d exp=61+-2", prog_time); else passed++;
`else
        checks++; if (prog_time !== '0) $display("FAIL nominal_prog_time got=%0d exp=0", prog_time); else passed++;
`endif
    endtask

    task automatic test_stuck_channel();
        int n;
        prog_done = 5'b11011;
        pulse_start();
        attempt_cycle("stuck1", 4'd1, 1'b1, 50, 5'b11011);
        attempt_cycle("stuck2", 4'd2, 1'b1, 50, 5'b11011);
        attempt_cycle("stuck3", 4'd3, 1'b1, 50, 5'b11011);
        n = 0;
        while (fail !== 1'b1 && n < 300) begin tick(); n++; end
        checks++; if (fail !== 1'b1) $display("FAIL stuck_fail got=%b exp=1", fail); else passed++;
        checks++; if (attempt !== 4'd3) $display("FAIL stuck_attempt got=%0d exp=3", attempt); else passed++;
        checks++; if (fail_mask !== 5'b00100) $display("FAIL stuck_mask got=%b exp=00100", fail_mask); else passed++;
        checks++; if (aborted !== 1'b0 || success !== 1'b0 || busy !== 1'b0)
            $display("FAIL stuck_flags got ab=%b succ=%b busy=%b exp 0/0/0", aborted, success, busy); else passed++;
    endtask

    task automatic test_retry_recovery();
        int n;
        prog_done = 5'h00;
        pulse_start();
        attempt_cycle("recov1", 4'd1, 1'b0, 0, 5'h00);
        attempt_cycle("recov2", 4'd2, 1'b1, 50, 5'h1F);
        n = 0;
        while (success !== 1'b1 && n < 50) begin tick(); n++; end
        checks++; if (success !== 1'b1 || attempt !== 4'd2 || fail !== 1'b0)
            $display("FAIL recovery got succ=%b att=%0d fail=%b exp 1/2/0", success, attempt, fail); else passed++;
    endtask

    task automatic test_abort();
        prog_done = 5'h00;
        pulse_start();
        checks++; if (prog_time !== '0) $display("FAIL start_clears_time got=%0d exp=0", prog_time); else passed++;
        attempt_cycle("abort", 4'd1, 1'b0, 0, 5'h00);
        tick(10);
        prog_in_progress = 1'b1;
        tick(5);
        prog_done = 5'h03;
        tick(3);
        abort_req = 1'b1;
        tick();
        abort_req = 1'b0;
        checks++; if (fail !== 1'b1 || aborted !== 1'b1) $display("FAIL abort_flags got fail=%b ab=%b exp 1/1", fail, aborted); else passed++;
        checks++; if (fail_mask !== 5'h1C) $display("FAIL abort_mask got=%h exp=1c", fail_mask); else passed++;
        checks++; if (prog_reset !== 1'b1 || prog_start !== 1'b0 || busy !== 1'b0)
            $display("FAIL abort_outputs got rst=%b start=%b busy=%b exp 1/0/0", prog_reset, prog_start, busy); else passed++;
        tick();
        prog_in_progress = 1'b0;
        checks++; if (prog_reset !== 1'b0) $display("FAIL abort_reset_pulse got=%b exp=0", prog_reset); else passed++;
    endtask

    task automatic test_simultaneous();
        int n;
        prog_done = 5'h00;
        pulse_start();
        attempt_cycle("simul", 4'd1, 1'b0, 0, 5'h00);
        start_req = 1'b1;
        abort_req = 1'b1;
        tick();
        start_req = 1'b0;
        abort_req = 1'b0;
        checks++; if (fail !== 1'b1 || aborted !== 1'b1 || attempt !== 4'd1)
            $display("FAIL simul_abort_wins got fail=%b ab=%b att=%0d exp 1/1/1", fail, aborted, attempt); else passed++;
        pulse_start();
        checks++; if (fail !== 1'b0 || aborted !== 1'b0 || fail_mask !== 5'h00 || attempt !== 4'd1 || busy !== 1'b1)
            $display("FAIL restart_from_fail got fail=%b ab=%b mask=%h att=%0d busy=%b exp 0/0/00/1/1",
                     fail, aborted, fail_mask, attempt, busy); else passed++;
        attempt_cycle("busy_start", 4'd1, 1'b0, 0, 5'h00);
        tick(5);
        pulse_start();
        checks++; if (attempt !== 4'd1 || busy !== 1'b1)
            $display("FAIL busy_start_ignored got att=%0d busy=%b exp 1/1", attempt, busy); else passed++;
        n = 6;
        while (prog_reset !== 1'b1 && n < 300) begin tick(); n++; end
        checks++; if (n != TIMEOUT_CYCLES) $display("FAIL timeout_latency got=%0d exp=%0d", n, TIMEOUT_CYCLES); else passed++;
        checks++; if (attempt !== 4'd2) $display("FAIL retry_attempt got=%0d exp=2", attempt); else passed++;
        abort_req = 1'b1;
        tick();
        abort_req = 1'b0;
        tick();
    endtask

    task automatic test_boundary();
        prog_done = 5'h00;
        pulse_start();
        attempt_cycle("boundary", 4'd1, 1'b0, 0, 5'h00);
        tick(10);
        prog_in_progress = 1'b1;
        tick(87);
        prog_done = 5'h1F;
        tick(2);
        prog_in_progress = 1'b0;
        tick();
        checks++; if (success !== 1'b1 || prog_reset !== 1'b0 || attempt !== 4'd1 || fail !== 1'b0)
            $display("FAIL success_vs_timeout got succ=%b rst=%b att=%0d fail=%b exp 1/0/1/0",
                     success, prog_reset, attempt, fail); else passed++;
`ifdef PROG_SUP_TIMER_EN
        checks++; if (prog_time !== 32'd99) $display("FAIL boundary_prog_time got=%0d exp=99", prog_time); else passed++;
`endif
        prog_done = 5'h00;
        pulse_start();
        checks++; if (prog_reset !== 1'b1 || busy !== 1'b1)
            $display("FAIL reset_prog_entry got rst=%b busy=%b exp 1/1", prog_reset, busy); else passed++;
        reset = 1'b1;
        tick();
        checks++; if ({prog_start, prog_reset, busy, success, fail, aborted} !== 6'b0 ||
                      attempt !== 4'd0 || fail_mask !== 5'd0 || prog_time !== '0)
            $display("FAIL midop_reset got flags=%b att=%0d mask=%h time=%0d exp 0",
                     {prog_start, prog_reset, busy, success, fail, aborted}, attempt, fail_mask, prog_time); else passed++;
        reset = 1'b0;
        tick(3);
        checks++; if (busy !== 1'b0 || prog_reset !== 1'b0)
            $display("FAIL midop_stays_idle got busy=%b rst=%b exp 0/0", busy, prog_reset); else passed++;
    endtask

    initial begin
        tick();
        test_reset();
        test_nominal();
        test_stuck_channel();
        test_retry_recovery();
        test_abort();
        test_simultaneous();
        test_boundary();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
